bcd2bin_seq: RTL and testbench

- Parametrised, digit-serial BCD-to-binary converter; successor to the fixed 2-digit bcd2bin.
- Converts an NDIG-digit packed BCD word to unsigned binary, one digit per clock, MSD first.
- Keeps the start/ready/done_tick handshake.
- Adds detection of invalid BCD digits (an error flag) and a continuous back-to-back mode when start is held high.

---
 rtl/bcd_pkg.sv | 44 ++++
 rtl/bcd2bin_seq_if.sv | 27 ++
 rtl/bcd_mac10.sv | 14 +
 rtl/bcd2bin_seq.sv | 113 +++++++++++
 tb/tb_bcd2bin_seq.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD-to-binary converter:
// digit width, FSM encoding, result-width helper and digit validity check.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int MAX_NDIG    = 9;
    localparam int BCD_MAX_W   = BCD_DIGIT_W * MAX_NDIG;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

    // ceil(log2(10^ndig)): smallest width that holds every ndig-digit decimal.
    function automatic int bin_width(input int ndig);
        longint p;
        longint one;
        int     w;
        p   = 1;
        one = 1;
        for (int i = 0; i < ndig; i++) begin
            p = p * 10;
        end
        w = 0;
        while ((one << w) < p) begin
            w = w + 1;
        end
        return w;
    endfunction

    // 1 when every one of the low ndig digits of word is in 0..9.
    function automatic logic bcd_valid(input logic [BCD_MAX_W-1:0] word, input int ndig);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_NDIG; i++) begin
            if (i < ndig && word[BCD_DIGIT_W*i +: BCD_DIGIT_W] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Request/result bundle of the BCD-to-binary converter.
//
// Handshake: the requester raises start with bcd stable; the converter takes
// the request on the first rising edge where start=1 and ready=1, and bcd is
// sampled only on that edge. done_tick pulses for one cycle in the cycle where
// bin/err first show the new result; bin/err then hold until the next result.
interface bcd2bin_seq_if #(
    parameter int NDIG  = 4,
    parameter int BIN_W = bcd_pkg::bin_width(NDIG)
);
    logic                                start;
    logic [bcd_pkg::BCD_DIGIT_W*NDIG-1:0] bcd;
    logic [BIN_W-1:0]                    bin;
    logic                                err;
    logic                                ready;
    logic                                done_tick;

    modport master (
        output start, bcd,
        input  bin, err, ready, done_tick
    );

    modport slave (
        input  start, bcd,
        output bin, err, ready, done_tick
    );
endinterface

// File: rtl/bcd_mac10.sv
// Combinational multiply-by-ten-and-add step: result = acc*10 + digit,
// built from shifts so no multiplier is needed.
module bcd_mac10 #(
    parameter int BIN_W = 14
) (
    input  logic [BIN_W-1:0] acc,
    input  logic [3:0]       digit,
    output logic [BIN_W-1:0] result
);
    // acc*10 = acc*8 + acc*2; the caller guarantees the true result fits BIN_W
    always_comb begin
        result = (acc << 3) + (acc << 1) + BIN_W'(digit);
    end
endmodule

// File: rtl/bcd2bin_seq.sv
// Digit-serial BCD-to-binary converter: one digit per clock, most significant
// digit first. Invalid digits (>9) are caught at request time and produce an
// immediate error result with bin forced to 0.
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    bcd2bin_seq_if.slave bus,
    output state_t       dbg_state
);
    localparam int BIN_W = bin_width(NDIG);
    localparam int BCD_W = BCD_DIGIT_W * NDIG;
    localparam int CNT_W = 4;

    state_t           state_q, state_d;
    logic [BIN_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic             err_q, err_d;

    logic [3:0]           digit;
    logic [BIN_W-1:0]     mac_out;
    logic [BCD_MAX_W-1:0] bcd_ext;

    assign bcd_ext = BCD_MAX_W'(bus.bcd);

    // pick the digit addressed by the down-counter (MSD first)
    always_comb begin
        digit = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                digit = bcd_q[BCD_DIGIT_W*i +: BCD_DIGIT_W];
            end
        end
    end

    bcd_mac10 #(.BIN_W(BIN_W)) u_mac (
        .acc    (acc_q),
        .digit  (digit),
        .result (mac_out)
    );

    // next-state and datapath update for the IDLE -> OP -> DONE sequence
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    bcd_d = bus.bcd;
                    if (!bcd_valid(bcd_ext, NDIG)) begin
                        err_d   = 1'b1;
                        bin_d   = '0;
                        state_d = DONE;
                    end else begin
                        acc_d   = '0;
                        cnt_d   = CNT_W'(NDIG - 1);
                        state_d = OP;
                    end
                end
            end
            OP: begin
                acc_d = mac_out;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    bin_d   = mac_out;
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and datapath registers; reset aborts any conversion in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
        end
    end

    assign bus.bin       = bin_q;
    assign bus.err       = err_q;
    assign bus.ready     = (state_q == IDLE);
    assign bus.done_tick = (state_q == DONE);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Bench for bcd2bin_seq: NDIG=4 and NDIG=2 instances, directed vectors with
// expected values computed here from plain decimal numbers.
module tb_bcd2bin_seq;
    import bcd_pkg::*;

    logic   clk;
    logic   rst_n;
    state_t st4, st2;

    int n_checks;
    int n_errors;

    logic [31:0] exp_q[$];

    bcd2bin_seq_if #(.NDIG(4)) bus4 ();
    bcd2bin_seq_if #(.NDIG(2)) bus2 ();

    bcd2bin_seq #(.NDIG(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus4.slave),
        .dbg_state (st4)
    );

    bcd2bin_seq #(.NDIG(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus2.slave),
        .dbg_state (st2)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd4(input int v);
        logic [15:0] w;
        w[15:12] = 4'((v / 1000) % 10);
        w[11:8]  = 4'((v / 100) % 10);
        w[7:4]   = 4'((v / 10) % 10);
        w[3:0]   = 4'(v % 10);
        return w;
    endfunction

    function automatic logic cur_ready(input int ndig);
        return (ndig == 4) ? bus4.ready : bus2.ready;
    endfunction

    function automatic logic cur_done(input int ndig);
        return (ndig == 4) ? bus4.done_tick : bus2.done_tick;
    endfunction

    function automatic logic [31:0] cur_bin(input int ndig);
        return (ndig == 4) ? 32'(bus4.bin) : 32'(bus2.bin);
    endfunction

    function automatic logic cur_err(input int ndig);
        return (ndig == 4) ? bus4.err : bus2.err;
    endfunction

    // driver: one request, then follow it to done_tick and check the result
    task automatic run_conv(input int ndig, input logic [15:0] word,
                            input int exp_bin, input logic exp_err);
        int n;
        int rdy_seen;
        n = 0;
        while (!cur_ready(ndig) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_before", 32'(cur_ready(ndig)), 1);
        if (ndig == 4) begin
            bus4.start = 1'b1;
            bus4.bcd   = word;
        end else begin
            bus2.start = 1'b1;
            bus2.bcd   = word[7:0];
        end
        @(posedge clk); #1;
        bus4.start = 1'b0;
        bus2.start = 1'b0;
        n        = 0;
        rdy_seen = 0;
        while (!cur_done(ndig) && n < 20) begin
            if (cur_ready(ndig)) rdy_seen++;
            @(posedge clk); #1;
            n++;
        end
        if (cur_ready(ndig)) rdy_seen++;
        check("latency", n, exp_err ? 0 : ndig);
        check("ready_busy", rdy_seen, 0);
        check("bin", cur_bin(ndig), exp_bin);
        check("err", 32'(cur_err(ndig)), 32'(exp_err));
    endtask

    initial begin
        logic [15:0] w;
        int          p;
        int          dec;
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        bus4.start = 1'b0;
        bus4.bcd   = '0;
        bus2.start = 1'b0;
        bus2.bcd   = '0;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_bin4", 32'(bus4.bin), 0);
        check("rst_err4", 32'(bus4.err), 0);
        check("rst_ready4", 32'(bus4.ready), 1);
        check("rst_done4", 32'(bus4.done_tick), 0);
        check("rst_state4", 32'(st4), 32'(IDLE));
        check("rst_ready2", 32'(bus2.ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // basic directed vectors
        run_conv(4, 16'h0000, 0, 1'b0);
        run_conv(4, 16'h9999, 9999, 1'b0);
        run_conv(4, 16'h12A4, 0, 1'b1);
        run_conv(4, 16'h0042, 42, 1'b0);
        run_conv(4, 16'hF000, 0, 1'b1);
        run_conv(4, 16'h1000, 1000, 1'b0);

        // back-to-back with start held: sampling every 6 cycles
        while (!bus4.ready) begin
            @(posedge clk); #1;
        end
        bus4.start = 1'b1;
        for (int j = 0; j < 24; j++) begin
            dec      = (j * 1237 + 11) % 10000;
            bus4.bcd = to_bcd4(dec);
            if (j % 6 == 0) exp_q.push_back(32'(dec));
            @(posedge clk); #1;
            if (j % 6 == 4) begin
                check("b2b_done", 32'(bus4.done_tick), 1);
                if (exp_q.size() > 0) check("b2b_bin", 32'(bus4.bin), exp_q.pop_front());
                else check("b2b_queue", 0, 1);
            end else begin
                check("b2b_nodone", 32'(bus4.done_tick), 0);
            end
        end
        bus4.start = 1'b0;
        check("b2b_left", exp_q.size(), 0);

        // reset mid-OP (cnt=2)
        run_conv(4, 16'h5678, 5678, 1'b0);
        @(posedge clk); #1;
        bus4.start = 1'b1;
        bus4.bcd   = 16'h1234;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        @(posedge clk); #1;
        check("midop_state", 32'(st4), 32'(OP));
        rst_n = 1'b0;
        #1;
        check("midop_bin", 32'(bus4.bin), 0);
        check("midop_err", 32'(bus4.err), 0);
        check("midop_ready", 32'(bus4.ready), 1);
        check("midop_done", 32'(bus4.done_tick), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_conv(4, 16'h0042, 42, 1'b0);

        // NDIG=2 exhaustive
        for (int v = 0; v < 100; v++) begin
            w = {8'h00, 4'(v / 10), 4'(v % 10)};
            run_conv(2, w, v, 1'b0);
        end
        run_conv(2, 16'h00A5, 0, 1'b1);

        // NDIG=4 exhaustive
        for (int v = 0; v < 10000; v++) begin
            run_conv(4, to_bcd4(v), v, 1'b0);
        end

        // NDIG=4 random invalid words: at least one digit forced to 10..15
        for (int k = 0; k < 1000; k++) begin
            w = 16'($urandom_range(0, 65535));
            p = $urandom_range(0, 3);
            w[4*p +: 4] = 4'($urandom_range(10, 15));
            run_conv(4, w, 0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
